// File: rtl/ahb2apb_bridge.sv
// ============================================================================
// ahb2apb_bridge
// ----------------------------------------------------------------------------
// Single-slave AHB-Lite to APB3 bridge. It handles one AHB NONSEQ/SEQ
// transfer at a time and turns it into an APB SETUP/ACCESS sequence. AHB is
// held off with hready_out until the APB side finishes.
//
// The AHB side moves on every sys_clk edge. The APB side moves only on
// sys_clk edges where pclk_en (from clock_div) is high. The APB signals are
// therefore synchronous to the divided pclk without needing a second clock.
//
// Handshake summary:
//   AHB: a transfer is accepted on an edge where
//        hsel & hready_in & htrans[1] holds and the bridge is in an
//        address-phase-capable state (IDLE, DONE, ERR2).
//        hwdata is taken in the following cycle, which is the data phase.
//        hready_out=0 stretches the data phase. An error is signalled by the
//        two-cycle pattern hresp=1/hready_out=0, then hresp=1/hready_out=1.
//   APB: psel rises on a pclk_en edge (SETUP). penable rises on the next
//        pclk_en edge (ACCESS). pready/pslverr are sampled only on pclk_en
//        edges while in ACCESS.
//
// Ports:
//   sys_clk     in   system clock, all flops on rising edge
//   rst_n       in   synchronous active-low reset
//   pclk_en     in   one-cycle APB enable strobe
//   hsel        in   AHB slave select
//   haddr       in   AHB address (address phase)
//   htrans      in   AHB transfer type, bit1=1 -> NONSEQ/SEQ
//   hwrite      in   AHB direction, 1=write
//   hwdata      in   AHB write data (data phase)
//   hready_in   in   bus HREADY
//   hready_out  out  slave ready / data-phase end
//   hresp       out  0=OKAY, 1=ERROR
//   hrdata      out  AHB read data
//   paddr       out  APB address
//   psel        out  APB select
//   penable     out  APB enable
//   pwrite      out  APB direction
//   pwdata      out  APB write data
//   prdata      in   APB read data
//   pready      in   APB ready
//   pslverr     in   APB slave error
//   state_dbg   out  current FSM state, for debug/observation only
// ============================================================================
module ahb2apb_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  pclk_en,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready_in,
    output logic                  hready_out,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [2:0]            state_dbg
);

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PEND   = 3'd1;  // accepted, waiting for a pclk_en edge
    localparam logic [2:0] S_SETUP  = 3'd2;  // psel=1, penable=0
    localparam logic [2:0] S_ACCESS = 3'd3;  // psel=1, penable=1, waiting for pready
    localparam logic [2:0] S_DONE   = 3'd4;  // OKAY response cycle
    localparam logic [2:0] S_ERR1   = 3'd5;  // first error cycle, hready_out=0
    localparam logic [2:0] S_ERR2   = 3'd6;  // second error cycle, hready_out=1

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;      // address captured in the AHB address phase
    logic                  write_q;     // direction captured in the AHB address phase
    logic                  data_phase;  // high during the first PEND cycle only
    logic                  addr_phase_ok;
    logic                  accept;

    // Only the low ADDR_WIDTH address bits reach APB. The upper bits are
    // reduced into a deliberately unused net.
    if (ADDR_WIDTH < 32) begin : g_unused_haddr
        logic unused_haddr_bits;
        assign unused_haddr_bits = ^haddr[31:ADDR_WIDTH];
    end

    // A new address phase can only be taken while hready_out is high, which
    // is exactly the IDLE, DONE and ERR2 states.
    always_comb begin
        addr_phase_ok = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR2: addr_phase_ok = 1'b1;
            default:                addr_phase_ok = 1'b0;
        endcase
    end

    assign accept = addr_phase_ok & hsel & hready_in & htrans[1];

    // AHB response outputs are a pure decode of the registered state.
    always_comb begin
        hready_out = 1'b1;
        hresp      = 1'b0;
        case (state)
            S_PEND, S_SETUP, S_ACCESS: begin
                hready_out = 1'b0;
                hresp      = 1'b0;
            end
            S_ERR1: begin
                hready_out = 1'b0;
                hresp      = 1'b1;
            end
            S_ERR2: begin
                hready_out = 1'b1;
                hresp      = 1'b1;
            end
            default: begin
                hready_out = 1'b1;
                hresp      = 1'b0;
            end
        endcase
    end

    assign state_dbg = state;

    // ------------------------------------------------------------------------
    // Main sequential block
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            // A reset mid-transfer drops psel/penable at once and gives no
            // AHB response.
            state      <= S_IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            data_phase <= 1'b0;
            hrdata     <= '0;
            paddr      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
        end else begin
            data_phase <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR2: begin
                    if (accept) begin
                        state      <= S_PEND;
                        addr_q     <= haddr[ADDR_WIDTH-1:0];
                        write_q    <= hwrite;
                        data_phase <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_PEND: begin
                    // hwdata is valid only in the cycle after the address
                    // phase, so it is captured at the end of the first PEND
                    // cycle whether or not a strobe arrives. Reads leave
                    // pwdata untouched.
                    if (data_phase && write_q) begin
                        pwdata <= hwdata;
                    end
                    if (pclk_en) begin
                        state  <= S_SETUP;
                        psel   <= 1'b1;
                        paddr  <= addr_q;
                        pwrite <= write_q;
                    end
                end

                S_SETUP: begin
                    if (pclk_en) begin
                        state   <= S_ACCESS;
                        penable <= 1'b1;
                    end
                end

                S_ACCESS: begin
                    // Between strobes pready/pslverr are not meaningful, so
                    // they are ignored.
                    if (pclk_en && pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            state <= S_ERR1;
                        end else begin
                            state <= S_DONE;
                            if (!write_q) begin
                                hrdata <= prdata;
                            end
                        end
                    end
                end

                S_ERR1: begin
                    state <= S_ERR2;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// ============================================================================
// tb_ahb2apb_bridge
// ----------------------------------------------------------------------------
// Directed bench for ahb2apb_bridge. A transaction-level model counts
// pclk_en strobes since acceptance to predict every DUT output, and is
// compared on every falling edge. Directed sections add hand-computed
// literal expectations.
// ============================================================================
module tb_ahb2apb_bridge;

  // --------------------------------------------------------------------------
  // clock / reset
  // --------------------------------------------------------------------------
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst_n;
  logic        pclk_en;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic        hresp;
  logic [31:0] hrdata;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [2:0]  state_dbg;

  // single-slave system: the bus HREADY is the slave's own hready_out
  assign hready_in = hready_out;

  ahb2apb_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .pclk_en    (pclk_en),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hwdata     (hwdata),
    .hready_in  (hready_in),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .state_dbg  (state_dbg)
  );

  // --------------------------------------------------------------------------
  // counters and check helpers
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // pclk_en generator + APB slave responder (one process, falling edge)
  //   pen_mode 0: strobe every 2nd cycle, 1: always 1, 2: stuck at 0
  //   Between strobes, pready/pslverr/prdata carry junk that must be ignored.
  // --------------------------------------------------------------------------
  int          pen_mode   = 0;
  int          pen_cnt    = 0;
  int          sl_waits   = 0;
  logic        sl_err     = 1'b0;
  logic [31:0] sl_rdata   = 32'h0;
  int          waits_left = 0;

  initial begin
    pclk_en = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    forever begin
      @(negedge sys_clk);
      pen_cnt++;
      case (pen_mode)
        0:       pclk_en = pen_cnt[0];
        1:       pclk_en = 1'b1;
        default: pclk_en = 1'b0;
      endcase
      if (psel && !penable) waits_left = sl_waits;
      if (psel && penable && pclk_en) begin
        if (waits_left > 0) begin
          pready  = 1'b0;
          pslverr = 1'b1;
          prdata  = $urandom;
          waits_left--;
        end else begin
          pready  = 1'b1;
          pslverr = sl_err;
          prdata  = sl_rdata;
        end
      end else begin
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = $urandom;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural model. It tracks one in-flight transfer by the number of
  // pclk_en strobes seen since acceptance: 0 -> waiting, >=1 -> psel,
  // >=2 -> penable, and completion on a strobe with pready at >=2.
  // m_resp: 0 none, 1 OKAY cycle, 2 first error cycle, 3 second error cycle.
  // --------------------------------------------------------------------------
  logic        m_valid = 1'b0;
  logic        m_busy, m_first, m_write, m_ready_now;
  int          m_n, m_resp;
  logic [15:0] m_addr, m_paddr;
  logic        m_pwrite;
  logic [31:0] m_pwdata, m_hrdata;

  always @(posedge sys_clk) begin
    if (!rst_n) begin
      m_valid  = 1'b1;
      m_busy   = 1'b0;
      m_first  = 1'b0;
      m_write  = 1'b0;
      m_n      = 0;
      m_resp   = 0;
      m_addr   = 16'h0;
      m_paddr  = 16'h0;
      m_pwrite = 1'b0;
      m_pwdata = 32'h0;
      m_hrdata = 32'h0;
    end else if (m_valid) begin
      if (m_busy) begin
        if (m_first && m_write) m_pwdata = hwdata;
        m_first = 1'b0;
        if (pclk_en) begin
          if (m_n == 0) begin
            m_n      = 1;
            m_paddr  = m_addr;
            m_pwrite = m_write;
          end else if (m_n == 1) begin
            m_n = 2;
          end else if (pready) begin
            m_busy = 1'b0;
            m_n    = 0;
            if (pslverr) begin
              m_resp = 2;
            end else begin
              m_resp = 1;
              if (!m_write) m_hrdata = prdata;
            end
          end
        end
      end else begin
        m_ready_now = (m_resp != 2);
        m_resp      = (m_resp == 2) ? 3 : 0;
        if (m_ready_now && hsel && htrans[1]) begin
          m_busy  = 1'b1;
          m_first = 1'b1;
          m_n     = 0;
          m_addr  = haddr[15:0];
          m_write = hwrite;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard compare: every cycle once the model has seen reset.
  // --------------------------------------------------------------------------
  always @(negedge sys_clk) begin
    if (m_valid) begin
      check1 ("cyc_hready_out", hready_out, !m_busy && (m_resp != 2));
      check1 ("cyc_hresp",      hresp,      (m_resp >= 2));
      check1 ("cyc_psel",       psel,       m_busy && (m_n >= 1));
      check1 ("cyc_penable",    penable,    m_busy && (m_n >= 2));
      check32("cyc_paddr",      32'(paddr), 32'(m_paddr));
      check1 ("cyc_pwrite",     pwrite,     m_pwrite);
      check32("cyc_pwdata",     pwdata,     m_pwdata);
      check32("cyc_hrdata",     hrdata,     m_hrdata);
    end
  end

  // --------------------------------------------------------------------------
  // AHB driver tasks
  // --------------------------------------------------------------------------
  // Called at a falling edge with hready_out high. Drives the address phase,
  // then the data phase. Returns in the first data-phase cycle.
  task automatic xfer_start(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hwdata = $urandom;
    @(negedge sys_clk);
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = $urandom;
    hwrite = 1'($urandom_range(0, 1));
    hwdata = wdata;
  endtask

  // Waits (bounded) until hready_out is high. waited counts the falling
  // edges after the first data-phase cycle. err_seen is hresp from the last
  // cycle where hready_out was low.
  task automatic wait_ready(input int budget, output int waited, output logic err_seen);
    waited   = 0;
    err_seen = hresp;
    do begin
      if (hready_out !== 1'b1) err_seen = hresp;
      @(negedge sys_clk);
      hwdata = $urandom;
      waited++;
    end while (hready_out !== 1'b1 && waited < budget);
    if (hready_out !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready_timeout: actual=hready_out low after %0d cycles required=high", waited);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  int   w;
  logic e;

  initial begin
    rst_n  = 1'b0;
    hsel   = 1'b0;
    haddr  = 32'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = 32'h0;

    // Reset: two edges low with pclk_en toggling
    repeat (2) @(negedge sys_clk);
    check1 ("rst_hready_out", hready_out, 1'b1);
    check1 ("rst_psel",       psel,       1'b0);
    check1 ("rst_penable",    penable,    1'b0);
    check1 ("rst_hresp",      hresp,      1'b0);
    check32("rst_hrdata",     hrdata,     32'h0);
    check32("rst_state",      32'(state_dbg), 32'h0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Write, strobe every 2nd cycle, no APB waits
    pen_mode = 0; sl_waits = 0; sl_err = 1'b0;
    xfer_start(32'h0000_1234, 1'b1, 32'hDEAD_BEEF);
    wait_ready(100, w, e);
    check1 ("wr_done_hresp", hresp,       1'b0);
    check32("wr_paddr",      32'(paddr),  32'h0000_1234);
    check1 ("wr_pwrite",     pwrite,      1'b1);
    check32("wr_pwdata",     pwdata,      32'hDEAD_BEEF);
    check1 ("wr_psel_off",   psel,        1'b0);
    @(negedge sys_clk);
    check1 ("wr_idle_ready", hready_out,  1'b1);

    // Read with 2 APB wait states; upper address bits are dropped
    sl_waits = 2; sl_rdata = 32'hA5A5_5A5A;
    xfer_start(32'hFFFF_0040, 1'b0, 32'h0BAD_0BAD);
    wait_ready(100, w, e);
    check32("rd_hrdata",     hrdata,      32'hA5A5_5A5A);
    check32("rd_paddr",      32'(paddr),  32'h0000_0040);
    check1 ("rd_pwrite",     pwrite,      1'b0);
    check32("rd_pwdata_hold", pwdata,     32'hDEAD_BEEF);
    @(negedge sys_clk);

    // Error on a read: two-cycle error response, hrdata unchanged
    sl_waits = 0; sl_err = 1'b1; sl_rdata = 32'h1234_5678;
    xfer_start(32'h0000_2000, 1'b0, 32'h0);
    wait_ready(100, w, e);
    check1 ("err1_hresp",    e,           1'b1);
    check1 ("err2_hresp",    hresp,       1'b1);
    check1 ("err2_hready",   hready_out,  1'b1);
    check32("err_hrdata",    hrdata,      32'hA5A5_5A5A);
    @(negedge sys_clk);
    check1 ("err_after_hresp", hresp,     1'b0);
    sl_err = 1'b0;

    // Back-to-back with pclk_en always high: 3 wait states each
    pen_mode = 1; sl_rdata = 32'h0BAD_F00D;
    @(negedge sys_clk);
    xfer_start(32'h0000_0010, 1'b1, 32'h1111_1111);
    wait_ready(100, w, e);
    check32("b2b_wr_waits",  32'(w),      32'd3);
    check32("b2b_wr_pwdata", pwdata,      32'h1111_1111);
    xfer_start(32'h0000_0020, 1'b0, 32'h0);  // presented in the DONE cycle
    wait_ready(100, w, e);
    check32("b2b_rd_waits",  32'(w),      32'd3);
    check32("b2b_rd_hrdata", hrdata,      32'h0BAD_F00D);
    check32("b2b_rd_paddr",  32'(paddr),  32'h0000_0020);
    @(negedge sys_clk);

    // Ignored address phases: hsel=0 NONSEQ, then BUSY, then IDLE
    hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_9999;
    @(negedge sys_clk);
    hsel = 1'b1; htrans = 2'b01;
    @(negedge sys_clk);
    hsel = 1'b1; htrans = 2'b00;
    @(negedge sys_clk);
    check1 ("ign_hready", hready_out, 1'b1);
    check1 ("ign_psel",   psel,       1'b0);
    hsel = 1'b0;

    // pclk_en stuck low: wait in PEND, write data still captured
    pen_mode = 2;
    repeat (2) @(negedge sys_clk);
    xfer_start(32'h0000_0300, 1'b1, 32'hCAFE_F00D);
    repeat (20) @(negedge sys_clk);
    check1 ("stuck_hready", hready_out, 1'b0);
    check1 ("stuck_psel",   psel,       1'b0);
    check32("stuck_pwdata", pwdata,     32'hCAFE_F00D);
    pen_mode = 0;
    wait_ready(100, w, e);
    check32("stuck_paddr",  32'(paddr), 32'h0000_0300);
    @(negedge sys_clk);

    // Abort: reset while in ACCESS
    pen_mode = 1; sl_waits = 10;
    xfer_start(32'h0000_0400, 1'b0, 32'h0);
    w = 0;
    while (!(psel === 1'b1 && penable === 1'b1) && w < 20) begin
      @(negedge sys_clk);
      w++;
    end
    check1("abort_in_access", psel && penable, 1'b1);
    rst_n = 1'b0;
    @(negedge sys_clk);
    check1 ("abort_psel",    psel,       1'b0);
    check1 ("abort_penable", penable,    1'b0);
    check1 ("abort_hready",  hready_out, 1'b1);
    check1 ("abort_hresp",   hresp,      1'b0);
    check32("abort_state",   32'(state_dbg), 32'h0);
    rst_n = 1'b1; sl_waits = 0;
    @(negedge sys_clk);

    // Recovery read after abort
    pen_mode = 0; sl_rdata = 32'h600D_D00D;
    xfer_start(32'h0000_0500, 1'b0, 32'h0);
    wait_ready(100, w, e);
    check32("post_abort_hrdata", hrdata, 32'h600D_D00D);
    repeat (3) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
